// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-load arbiter: FSM encoding, default
// sizes and a one-hot to index helper.
package reg_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_VERIFY = 2'd3
  } state_t;

  // Index of the set bit of a one-hot vector (up to 8 requesters).
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: the search starts one past the last
// owner and wraps; the first active request found wins.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  // Walk the requesters in rotated order and keep the first hit.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = IDX_W'((int'(last_owner) + off) % N_REQ);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters write a shared register,
// then reads it back and reports completion (and any readback mismatch).
// A transfer is IDLE -> LOAD -> WAIT -> VERIFY, four cycles end to end.
module reg_load_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] ReqData,
  output logic [N_REQ-1:0]       Grant,
  output logic [N_REQ-1:0]       Done,
  output logic                   Mismatch,
  output logic                   Busy,
  output logic [WIDTH-1:0]       RegDataIn,
  output logic                   RegLoad,
  input  logic [WIDTH-1:0]       RegDataOut
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               mismatch_q, mismatch_d;
  logic               busy_q, busy_d;
  logic               load_q, load_d;

  logic [N_REQ-1:0]   sel_grant;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   masked_data [N_REQ];

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req        (Req),
    .last_owner (last_owner_q),
    .grant      (sel_grant),
    .valid      (sel_valid)
  );

  assign sel_idx = IDX_W'(onehot_to_idx(8'(sel_grant)));

  // Zero every data slice except the winner's so an OR-reduce picks it.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign masked_data[gi] = sel_grant[gi] ? ReqData[gi*WIDTH +: WIDTH] : '0;
  end

  // OR-reduce the masked slices into the winner's write data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data = sel_data | masked_data[i];
    end
  end

  // Next-state and next-output logic; outputs are all registered so each
  // state's outputs are computed on the transition into it. The readback is
  // sampled during WAIT so Done/Mismatch can be presented from a flop in VERIFY.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    data_d       = data_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    done_d       = '0;
    mismatch_d   = 1'b0;
    load_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d      = ST_LOAD;
          last_owner_d = sel_idx;
          data_d       = sel_data;
          grant_d      = sel_grant;
          busy_d       = 1'b1;
          load_d       = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d    = ST_VERIFY;
        done_d     = grant_q;
        mismatch_d = (RegDataOut != data_q);
      end
      ST_VERIFY: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= IDX_W'(N_REQ - 1);
      data_q       <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      mismatch_q   <= 1'b0;
      busy_q       <= 1'b0;
      load_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      mismatch_q   <= mismatch_d;
      busy_q       <= busy_d;
      load_q       <= load_d;
    end
  end

  assign Grant     = grant_q;
  assign Done      = done_q;
  assign Mismatch  = mismatch_q;
  assign Busy      = busy_q;
  assign RegLoad   = load_q;
  assign RegDataIn = data_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Scoreboard bench for reg_load_arbiter: stimulus pushes expected loads and
// completions, a negedge monitor pops and compares them as the DUT shows them.
module tb_reg_load_arbiter;

  logic        Clk;
  logic        Reset;
  logic [3:0]  Req;
  logic [31:0] req_data;
  logic [3:0]  Grant;
  logic [3:0]  Done;
  logic        Mismatch;
  logic        Busy;
  logic [7:0]  RegDataIn;
  logic        RegLoad;
  logic [7:0]  RegDataOut;
  logic [7:0]  shadow_reg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] oh;
    logic [7:0] data;
    logic       mm;
  } exp_t;

  exp_t load_q[$];
  exp_t done_q[$];
  exp_t mon_e;

  reg_load_arbiter #(.WIDTH(8), .N_REQ(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .ReqData    (req_data),
    .Grant      (Grant),
    .Done       (Done),
    .Mismatch   (Mismatch),
    .Busy       (Busy),
    .RegDataIn  (RegDataIn),
    .RegLoad    (RegLoad),
    .RegDataOut (RegDataOut)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Shared register model; writing 8'h3C is corrupted to 8'h00 on purpose.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) shadow_reg <= 8'h00;
    else if (RegLoad) shadow_reg <= (RegDataIn == 8'h3C) ? 8'h00 : RegDataIn;
  end
  assign RegDataOut = shadow_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] d, input logic mm,
                          input logic with_done, input int lc);
    exp_t e;
    e.cyc  = lc;
    e.oh   = 4'(1 << idx);
    e.data = d;
    e.mm   = mm;
    load_q.push_back(e);
    if (with_done) begin
      e.cyc = lc + 2;
      done_q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, Grant, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_mismatch"}, Mismatch, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_regload"}, RegLoad, 0);
    chk({tag, "_regdatain"}, RegDataIn, 0);
  endtask

  // Monitor: compare every load and every completion against the queues.
  always @(negedge Clk) begin
    if (Reset) begin
      if (RegLoad) begin
        if (load_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load: cyc=%0d grant=%b data=%h expected no load", cyc, Grant, RegDataIn);
        end else begin
          mon_e = load_q.pop_front();
          chk("load_cycle", cyc, mon_e.cyc);
          chk("load_grant", Grant, mon_e.oh);
          chk("load_data", RegDataIn, mon_e.data);
        end
      end
      if (Done != 4'b0 || Mismatch) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: cyc=%0d done=%b mismatch=%b expected none", cyc, Done, Mismatch);
        end else begin
          mon_e = done_q.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("done_owner", Done, mon_e.oh);
          chk("done_mismatch", Mismatch, mon_e.mm);
          $display("xfer done=%b data=%h mismatch=%b cyc=%0d", Done, mon_e.data, Mismatch, cyc);
        end
      end
    end
  end

  initial begin
    int c;
    Reset    = 1'b1;
    Req      = 4'b0;
    req_data = 32'h0;
    #2 Reset = 1'b0;
    @(negedge Clk);
    check_zero("reset");
    @(posedge Clk); #1;
    Reset = 1'b1;

    // Single request, requester 1, data A5
    req_data = 32'h0000_A500;
    Req      = 4'b0010;
    push_exp(1, 8'hA5, 1'b0, 1'b1, cyc + 1);
    tick(1);
    Req = 4'b0;
    chk("busy_in_load", Busy, 1);
    chk("grant_in_load", Grant, 4'b0010);
    tick(5);
    chk("busy_idle", Busy, 0);
    chk("grant_idle", Grant, 0);

    // Fresh reset so requester 0 has top priority, then everyone requests
    Reset = 1'b0;
    #1 check_zero("pulse_reset");
    tick(1);
    Reset    = 1'b1;
    req_data = 32'h4030_2010;
    Req      = 4'b1111;
    c = cyc;
    for (int i = 0; i < 8; i++) push_exp(i % 4, 8'((i % 4 + 1) * 16), 1'b0, 1'b1, c + 1 + 4 * i);
    tick(32);
    Req = 4'b0;
    tick(4);

    // Requesters 0 and 3 hold their requests: they must alternate
    req_data = 32'hB300_00A0;
    Req      = 4'b1001;
    c = cyc;
    for (int i = 0; i < 4; i++) push_exp((i % 2 == 0) ? 0 : 3, (i % 2 == 0) ? 8'hA0 : 8'hB3, 1'b0, 1'b1, c + 1 + 4 * i);
    tick(16);
    Req = 4'b0;
    tick(4);

    // Readback fault on 3C, then back-to-back clean write from the same requester
    req_data = 32'h003C_0000;
    Req      = 4'b0100;
    c = cyc;
    push_exp(2, 8'h3C, 1'b1, 1'b1, c + 1);
    push_exp(2, 8'h5A, 1'b0, 1'b1, c + 5);
    tick(1);
    req_data[23:16] = 8'h5A;
    tick(4);
    Req = 4'b0;
    tick(4);
    chk("mismatch_not_sticky", Mismatch, 0);

    // Request dropped and data changed during LOAD must not disturb the transfer
    req_data = 32'h0000_1100;
    Req      = 4'b0010;
    push_exp(1, 8'h11, 1'b0, 1'b1, cyc + 1);
    tick(1);
    Req             = 4'b0;
    req_data[15:8]  = 8'h22;
    tick(5);

    // Reset during WAIT of requester 2 aborts it without Done
    req_data = 32'h0077_0000;
    Req      = 4'b0100;
    push_exp(2, 8'h77, 1'b0, 1'b0, cyc + 1);
    tick(1);
    Req = 4'b0;
    tick(1);
    Reset = 1'b0;
    #1 check_zero("abort");
    tick(1);
    Reset    = 1'b1;
    req_data = 32'h00C2_00C0;
    Req      = 4'b0101;
    c = cyc;
    push_exp(0, 8'hC0, 1'b0, 1'b1, c + 1);
    push_exp(2, 8'hC2, 1'b0, 1'b1, c + 5);
    tick(5);
    Req = 4'b0;
    tick(6);

    chk("load_queue_left", load_q.size(), 0);
    chk("done_queue_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
